// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder
//   Wishbone address decoder / interconnect between one master and
//   NUM_SLAVES slaves. The master's cyc/stb go to exactly one slave, chosen
//   by a base/mask match, and that slave's read data and ack come back to
//   the master. The block also locks the slave choice for a whole cycle
//   (bursts), reports unmapped addresses with err, and runs a watchdog that
//   reports err when the selected slave stalls.
//   adr/dat/we/sel/cti/bte fan out from the master to every slave
//   directly; they do not pass through here.
//
// Ports
//   clock_i          system clock
//   reset_n_i        synchronous reset, active low
//   adr_i            master address (used for decode only)
//   stb_i, cyc_i     master strobe / cycle
//   dat_o            read data to master (0 when no slave is selected)
//   ack_o            acknowledge to master
//   err_o            bus error to master (registered one-cycle pulse)
//   s_stb_o, s_cyc_o per-slave strobe / cycle
//   s_dat_i          per-slave read data, slave k at [32k+31:32k]
//   s_ack_i          per-slave ack
//   timeout_count_o  saturating count of watchdog errors
//
// Handshake: a beat is offered while cyc_i && stb_i are high. It ends in
// the cycle where ack_o or err_o is high; these two are never high
// together. A routed beat reaches its slave in the same cycle, with no
// added latency.
module wb_slave_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE =
    {32'h20000000, 32'h10000000, 32'h00000000, 32'ha0000000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK =
    {32'hf0000000, 32'hf0000000, 32'hf0000000, 32'hffffffff},
  parameter int TIMEOUT = 255,
  parameter int CW = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic [31:0]              adr_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic [31:0]              dat_o,
  output logic                     ack_o,
  output logic                     err_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic [NUM_SLAVES-1:0]    s_cyc_o,
  input  logic [32*NUM_SLAVES-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i,
  output logic [15:0]              timeout_count_o
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERROR} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   sel_idx_q, sel_idx_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;
  logic [15:0]     tmo_q, tmo_d;

  logic            hit_any;
  logic [IW-1:0]   hit_idx;
  logic            route_en;
  logic [IW-1:0]   route_idx;
  logic            ack_int;

  // Walk from the highest index down so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((adr_i & SLAVE_MASK[32*k +: 32]) ==
          (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32])) begin
        hit_any = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  // Next state, routing selection, error pulse and timeout count.
  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    err_d     = 1'b0;
    tmo_d     = tmo_q;
    route_en  = 1'b0;
    route_idx = sel_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          if (hit_any) begin
            route_en  = 1'b1;
            route_idx = hit_idx;
            sel_idx_d = hit_idx;
            state_d   = ST_ACTIVE;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // The slave chosen at the start of the cycle stays selected until
        // cyc_i drops, even if a burst address walks into another range.
        route_en = 1'b1;
        if (!cyc_i) begin
          state_d = ST_IDLE;
        end else if (stb_i && !s_ack_i[sel_idx_q] && (wd_q == WD_LAST)) begin
          // An ack in this same cycle takes priority, so the beat is not
          // treated as a timeout. Otherwise the strobe stays on here and is
          // cut next cycle, when the state is ERROR.
          state_d = ST_ERROR;
          err_d   = 1'b1;
          tmo_d   = (tmo_q == 16'hffff) ? tmo_q : tmo_q + 16'd1;
        end
      end
      ST_ERROR: begin
        // This is the err pulse cycle, and no slave is driven. IDLE then
        // either sits idle or decodes a strobe the master still holds as a
        // new beat.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack_int = route_en & s_ack_i[route_idx];

  // Watchdog: counts stalled strobe cycles while a slave is selected.
  always_comb begin
    if ((state_d != state_q) || ack_int || !stb_i) begin
      wd_d = '0;
    end else if (state_q == ST_ACTIVE) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = wd_q;
    end
  end

  // Slave fan-out and read mux. While reset is held, everything is forced
  // quiet without waiting for a clock edge.
  always_comb begin
    s_stb_o = '0;
    s_cyc_o = '0;
    ack_o   = 1'b0;
    dat_o   = '0;
    if (reset_n_i && route_en) begin
      s_stb_o[route_idx] = stb_i;
      s_cyc_o[route_idx] = cyc_i;
      ack_o              = ack_int;
      dat_o              = s_dat_i[32*route_idx +: 32];
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
      wd_q      <= wd_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign err_o           = err_q;
  assign timeout_count_o = tmo_q;

endmodule
